// File: rtl/alu_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_nibble_sequencer
// Purpose  : Runs one wide operation through a 4-bit ALU, one nibble per
//            cycle (LSB first), chaining carry and assembling the result.
// Revision : 1.0  initial release
// ============================================================================
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic [1:0]             in_op,
    input  logic                   in_cin,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic                   alu_cin,
    output logic [1:0]             alu_s_op,
    input  logic [3:0]             alu_z,
    input  logic                   alu_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_z,
    output logic                   out_cout
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [1:0]       r_op;
    logic             r_c;
    logic [IDX_W-1:0] r_idx;
    logic             w_run;

    // Handshake flags come from the state register alone, never from inputs.
    assign w_run     = (r_state == S_RUN);
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);

    assign alu_a    = w_run ? r_a[4*r_idx +: 4] : 4'd0;
    assign alu_b    = w_run ? r_b[4*r_idx +: 4] : 4'd0;
    assign alu_cin  = w_run ? r_c               : 1'b0;
    assign alu_s_op = w_run ? r_op              : 2'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 2'd0;
            r_c      <= 1'b0;
            r_idx    <= '0;
            out_z    <= '0;
            out_cout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= in_a;
                        r_b      <= in_b;
                        r_op     <= in_op;
                        r_c      <= in_cin;
                        r_idx    <= '0;
                        out_z    <= '0;
                        out_cout <= 1'b0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Carry is chained regardless of op; the ALU owns its meaning.
                    out_z[4*r_idx +: 4] <= alu_z;
                    r_c                 <= alu_cout;
                    if (r_idx == c_last_idx) begin
                        out_cout <= alu_cout;
                        r_state  <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_nibble_sequencer
// Purpose  : Self-checking bench: vector table, random ops against a wide
//            arithmetic reference, and hand-written multi-cycle sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_nibble_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid, in_ready, in_cin, alu_cin, alu_cout;
    logic        out_valid, out_ready, out_cout;
    logic [15:0] in_a, in_b, out_z;
    logic [1:0]  in_op, alu_s_op;
    logic [3:0]  alu_a, alu_b, alu_z;

    logic        s_in_valid, s_in_ready, s_in_cin, s_alu_cin, s_alu_cout;
    logic        s_out_valid, s_out_ready, s_out_cout;
    logic [3:0]  s_in_a, s_in_b, s_out_z, s_alu_a, s_alu_b, s_alu_z;
    logic [1:0]  s_in_op, s_alu_s_op;

    int          errors = 0;
    int          checks = 0;
    int          lat;
    logic [15:0] seq_a_p;
    logic [3:0]  seq_cin_p;
    logic [7:0]  seq_op_p;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic        cin;
        logic [15:0] z;
        logic        cout;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    // Environment ALU: 00 add, 01 subtract (a + ~b + cin), 10 and, 11 xor.
    function automatic logic [4:0] alu_nib(input logic [1:0] op, input logic [3:0] a,
                                           input logic [3:0] b, input logic cin);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b} + 5'(cin);
            2'd1:    return {1'b0, a} + {1'b0, ~b} + 5'(cin);
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    // Whole-word reference: chained nibbles behave as one wide operation.
    function automatic logic [16:0] ref_op(input logic [1:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic cin);
        case (op)
            2'd0:    return {1'b0, a} + {1'b0, b} + 17'(cin);
            2'd1:    return {1'b0, a} + {1'b0, ~b} + 17'(cin);
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    assign {alu_cout, alu_z}     = alu_nib(alu_s_op, alu_a, alu_b, alu_cin);
    assign {s_alu_cout, s_alu_z} = alu_nib(s_alu_s_op, s_alu_a, s_alu_b, s_alu_cin);

    alu_nibble_sequencer #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_s_op(alu_s_op),
        .alu_z(alu_z), .alu_cout(alu_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_cout(out_cout)
    );

    alu_nibble_sequencer #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_op(s_in_op), .in_cin(s_in_cin),
        .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_cin(s_alu_cin), .alu_s_op(s_alu_s_op),
        .alu_z(s_alu_z), .alu_cout(s_alu_cout),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_z(s_out_z), .out_cout(s_out_cout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic [1:0] op, input logic cin, input logic keep);
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_cin   = cin;
        in_valid = 1'b1;
        chk("accept_ready", in_ready, 1);
        tick();
        in_valid = keep;
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
        in_op    = 2'($urandom);
        in_cin   = 1'($urandom);
    endtask

    // Records per-cycle ALU drive until out_valid, bounded.
    task automatic collect;
        int n;
        n         = 0;
        seq_a_p   = '0;
        seq_cin_p = '0;
        seq_op_p  = '0;
        while (!out_valid && n < 40) begin
            if (n < 4) begin
                seq_a_p[4*n +: 4] = alu_a;
                seq_cin_p[n]      = alu_cin;
                seq_op_p[2*n +: 2] = alu_s_op;
            end
            tick();
            n++;
        end
        lat = n;
    endtask

    task automatic finish_op;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_ready", in_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [16:0] exp;
        logic [15:0] ra, rb, hold_z;
        logic [1:0]  rop;
        logic        rcin, hold_c, ok;

        vecs[0] = '{16'h1234, 16'h0FFF, 2'd0, 1'b0, 16'h2233, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 2'd0, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h00FF, 16'h0F0F, 2'd2, 1'b0, 16'h000F, 1'b0};
        vecs[3] = '{16'hA5A5, 16'hFFFF, 2'd3, 1'b0, 16'h5A5A, 1'b0};
        vecs[4] = '{16'h0005, 16'h0003, 2'd1, 1'b1, 16'h0002, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 2'd0, 1'b1, 16'h0001, 1'b1};

        in_valid = 0; in_a = 0; in_b = 0; in_op = 0; in_cin = 0; out_ready = 0;
        s_in_valid = 0; s_in_a = 0; s_in_b = 0; s_in_op = 0; s_in_cin = 0; s_out_ready = 0;

        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_z", out_z, 0);
        chk("rst_out_cout", out_cout, 0);
        chk("rst_alu_ab", {alu_a, alu_b}, 0);
        chk("rst_alu_cin", alu_cin, 0);
        chk("rst_alu_s_op", alu_s_op, 0);
        chk("rst_n1_in_ready", s_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].cin, 1'b0);
            collect();
            chk($sformatf("vec%0d_latency", i), lat, 4);
            chk($sformatf("vec%0d_alu_a_seq", i), seq_a_p, vecs[i].a);
            chk($sformatf("vec%0d_s_op_seq", i), seq_op_p, {4{vecs[i].op}});
            chk($sformatf("vec%0d_out_z", i), out_z, vecs[i].z);
            chk($sformatf("vec%0d_out_cout", i), out_cout, vecs[i].cout);
            if (i == 1) chk("ripple_cin_seq", seq_cin_p, 4'b1110);
            chk($sformatf("vec%0d_alu_idle_done", i), {alu_a, alu_b, alu_cin, alu_s_op}, 0);
            finish_op();
        end

        for (int i = 0; i < 30; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rop  = 2'($urandom_range(0, 3));
            rcin = 1'($urandom);
            exp  = ref_op(rop, ra, rb, rcin);
            start_op(ra, rb, rop, rcin, 1'b0);
            collect();
            chk($sformatf("rnd%0d_latency", i), lat, 4);
            chk($sformatf("rnd%0d_out_z", i), out_z, exp[15:0]);
            chk($sformatf("rnd%0d_out_cout", i), out_cout, exp[16]);
            finish_op();
        end

        // Output backpressure with in_valid held high.
        start_op(16'h1234, 16'h0FFF, 2'd0, 1'b0, 1'b1);
        collect();
        chk("bp_latency", lat, 4);
        hold_z = out_z;
        hold_c = out_cout;
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_z !== hold_z || out_cout !== hold_c)
                ok = 1'b0;
        end
        chk("bp_stable", ok, 1);
        chk("bp_out_z", out_z, 16'h2233);
        in_a = 16'h0001; in_b = 16'h0002; in_op = 2'd0; in_cin = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_not_accepted", in_ready, 1);
        chk("bp_idle_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("bp_next_accepted", in_ready, 0);
        collect();
        chk("bp_next_latency", lat, 4);
        chk("bp_next_out_z", out_z, 16'h0003);
        finish_op();

        // Reset in the middle of an operation.
        start_op(16'h1234, 16'h0FFF, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk("midrst_partial_z", out_z, 16'h0033);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_z", out_z, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_alu", {alu_a, alu_b, alu_cin, alu_s_op}, 0);
        chk("midrst_out_cout", out_cout, 0);
        ok = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (out_valid !== 1'b0) ok = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) ok = 1'b0;
        end
        chk("midrst_no_result", ok, 1);
        start_op(16'h0001, 16'h0001, 2'd0, 1'b0, 1'b0);
        collect();
        chk("midrst_after_latency", lat, 4);
        chk("midrst_after_out_z", out_z, 16'h0002);
        finish_op();

        // Single-nibble configuration.
        s_in_a = 4'hF; s_in_b = 4'h1; s_in_op = 2'd0; s_in_cin = 1'b1;
        s_in_valid = 1'b1;
        chk("n1_accept_ready", s_in_ready, 1);
        tick();
        s_in_valid = 1'b0;
        s_in_a = 4'($urandom); s_in_b = 4'($urandom); s_in_cin = 1'($urandom);
        lat = 0;
        while (!s_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("n1_latency", lat, 1);
        chk("n1_out_z", s_out_z, 4'h1);
        chk("n1_out_cout", s_out_cout, 1);
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
        chk("n1_release", {s_out_valid, s_in_ready}, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
